// File: rtl/policy_deck_if.sv
// Command/status bundle for the policy-card sequencer: one command channel plus
// the game-state view and debug taps (stack bits, FSM state) for checkers.
interface policy_deck_if #(
    parameter int DECK_SIZE = 17
);
    // Handshake: a command is taken on a rising clk edge where cmd_valid and
    // cmd_ready are both high; cmd_op/cmd_idx must be stable while cmd_valid is
    // high. The sequencer answers each accepted command with a one-cycle done
    // or err pulse (NOP answers with neither).
    logic                 cmd_valid;
    logic [2:0]           cmd_op;
    logic [1:0]           cmd_idx;
    logic                 cmd_ready;
    logic                 done;
    logic                 err;
    logic [2:0]           hand;
    logic [1:0]           hand_n;
    logic [2:0]           peek;
    logic [4:0]           stack_n;
    logic [4:0]           disc_n;
    logic [2:0]           lib_board;
    logic [2:0]           fas_board;
    logic                 game_over;
    logic [DECK_SIZE-1:0] dbg_stack;
    logic [1:0]           dbg_state;

    modport master (
        output cmd_valid, cmd_op, cmd_idx,
        input  cmd_ready, done, err, hand, hand_n, peek, stack_n, disc_n,
               lib_board, fas_board, game_over, dbg_stack, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx,
        output cmd_ready, done, err, hand, hand_n, peek, stack_n, disc_n,
               lib_board, fas_board, game_over, dbg_stack, dbg_state
    );
endinterface

// File: rtl/policy_deck_ctrl.sv
// Policy-card sequencer: draw stack, hand, discard counts, boards, merge+shuffle.
// Optional SNPU_ENTROPY_EN adds ent_in, mixed into the LFSR feedback.
module policy_deck_ctrl #(
    parameter int          DECK_SIZE   = 17,
    parameter int          N_ONES      = 6,
    parameter int          SHUF_ROUNDS = 32,
    parameter logic [7:0]  LFSR_SEED   = 8'h01
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SNPU_ENTROPY_EN
    input  logic          ent_in,
`endif
    policy_deck_if.slave  bus
);
    localparam int RW = $clog2(SHUF_ROUNDS + 1);
    localparam logic [DECK_SIZE-1:0] FRESH = {{(DECK_SIZE-N_ONES){1'b0}}, {N_ONES{1'b1}}};

    typedef enum logic [1:0] {IDLE, MERGE, SHUF, DRAW_FIN} state_t;

    state_t               state_q, state_d;
    logic [DECK_SIZE-1:0] stack_q, stack_d;
    logic [4:0]           stack_n_q, stack_n_d, disc_n_q, disc_n_d, disc_ones_q, disc_ones_d;
    logic [2:0]           hand_q, hand_d, peek_q, peek_d, lib_q, lib_d, fas_q, fas_d;
    logic [1:0]           hand_n_q, hand_n_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [4:0]           i_q, i_d;
    logic [RW-1:0]        rnd_q, rnd_d;
    logic                 draw_pend_q, draw_pend_d, done_q, done_d, err_q, err_d;
    logic                 fb, card, other, game_over;
    int                   sn, dn, dos;

    assign game_over = (lib_q == 3'd5) || (fas_q == 3'd6);

    always_comb begin
        state_d     = state_q;
        stack_d     = stack_q;
        stack_n_d   = stack_n_q;
        disc_n_d    = disc_n_q;
        disc_ones_d = disc_ones_q;
        hand_d      = hand_q;
        hand_n_d    = hand_n_q;
        peek_d      = peek_q;
        lib_d       = lib_q;
        fas_d       = fas_q;
        i_d         = i_q;
        rnd_d       = rnd_q;
        draw_pend_d = draw_pend_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        card        = 1'b0;
        other       = 1'b0;
        sn          = int'(stack_n_q);
        dn          = int'(disc_n_q);
        dos         = int'(disc_ones_q);

        fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
`ifdef SNPU_ENTROPY_EN
        fb     = fb ^ ent_in;
        lfsr_d = (lfsr_q == 8'h00) ? LFSR_SEED : {lfsr_q[6:0], fb};
`else
        lfsr_d = {lfsr_q[6:0], fb};
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    err_d = 1'b1;
                    if (bus.cmd_op == 3'd0) begin
                        err_d = 1'b0;
                    end else if (bus.cmd_op == 3'd1) begin
                        // Fresh game keeps the LFSR running so games differ.
                        err_d     = 1'b0;
                        done_d    = 1'b1;
                        stack_d   = FRESH;
                        stack_n_d = 5'(DECK_SIZE);
                        disc_n_d  = '0;
                        disc_ones_d = '0;
                        hand_d    = '0;
                        hand_n_d  = '0;
                        peek_d    = '0;
                        lib_d     = '0;
                        fas_d     = '0;
                    end else if (!game_over) begin
                        case (bus.cmd_op)
                            3'd2: if (hand_n_q == 2'd0) begin
                                if (stack_n_q >= 5'd3) begin
                                    err_d     = 1'b0;
                                    done_d    = 1'b1;
                                    hand_d    = stack_q[2:0];
                                    hand_n_d  = 2'd3;
                                    stack_d   = stack_q >> 3;
                                    stack_n_d = stack_n_q - 5'd3;
                                end else if (sn + dn >= 3) begin
                                    err_d       = 1'b0;
                                    draw_pend_d = 1'b1;
                                    state_d     = MERGE;
                                end
                            end
                            3'd3: if (hand_n_q == 2'd3 && bus.cmd_idx != 2'd3) begin
                                err_d    = 1'b0;
                                done_d   = 1'b1;
                                hand_n_d = 2'd2;
                                case (bus.cmd_idx)
                                    2'd0:    begin card = hand_q[0]; hand_d = {1'b0, hand_q[2], hand_q[1]}; end
                                    2'd1:    begin card = hand_q[1]; hand_d = {1'b0, hand_q[2], hand_q[0]}; end
                                    default: begin card = hand_q[2]; hand_d = {1'b0, hand_q[1], hand_q[0]}; end
                                endcase
                                disc_n_d    = disc_n_q + 5'd1;
                                disc_ones_d = disc_ones_q + {4'd0, card};
                            end
                            3'd4: if (hand_n_q == 2'd2 && !bus.cmd_idx[1]) begin
                                err_d    = 1'b0;
                                done_d   = 1'b1;
                                card     = bus.cmd_idx[0] ? hand_q[1] : hand_q[0];
                                other    = bus.cmd_idx[0] ? hand_q[0] : hand_q[1];
                                if (card) lib_d = lib_q + 3'd1;
                                else      fas_d = fas_q + 3'd1;
                                disc_n_d    = disc_n_q + 5'd1;
                                disc_ones_d = disc_ones_q + {4'd0, other};
                                hand_d      = '0;
                                hand_n_d    = '0;
                            end
                            3'd5: if (stack_n_q >= 5'd3) begin
                                err_d  = 1'b0;
                                done_d = 1'b1;
                                peek_d = stack_q[2:0];
                            end
                            3'd6: if (hand_n_q == 2'd0) begin
                                err_d       = 1'b0;
                                draw_pend_d = 1'b0;
                                state_d     = MERGE;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            MERGE: begin
                // Discards go on the bottom: ones first, then zeros.
                for (int k = 0; k < DECK_SIZE; k++) begin
                    if (k >= sn && k < sn + dn) stack_d[k] = ((k - sn) < dos);
                end
                stack_n_d   = stack_n_q + disc_n_q;
                disc_n_d    = '0;
                disc_ones_d = '0;
                i_d         = '0;
                rnd_d       = '0;
                state_d     = SHUF;
            end
            SHUF: begin
                if (int'(lfsr_q[4:0]) < sn) begin
                    stack_d[i_q]         = stack_q[lfsr_q[4:0]];
                    stack_d[lfsr_q[4:0]] = stack_q[i_q];
                end
                i_d = (int'(i_q) + 1 >= sn) ? 5'd0 : i_q + 5'd1;
                if (rnd_q == RW'(SHUF_ROUNDS - 1)) begin
                    state_d = draw_pend_q ? DRAW_FIN : IDLE;
                    done_d  = !draw_pend_q;
                end else begin
                    rnd_d = rnd_q + RW'(1);
                end
            end
            DRAW_FIN: begin
                hand_d      = stack_q[2:0];
                hand_n_d    = 2'd3;
                stack_d     = stack_q >> 3;
                stack_n_d   = stack_n_q - 5'd3;
                draw_pend_d = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stack_q     <= FRESH;
            stack_n_q   <= 5'(DECK_SIZE);
            disc_n_q    <= '0;
            disc_ones_q <= '0;
            hand_q      <= '0;
            hand_n_q    <= '0;
            peek_q      <= '0;
            lib_q       <= '0;
            fas_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            i_q         <= '0;
            rnd_q       <= '0;
            draw_pend_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stack_q     <= stack_d;
            stack_n_q   <= stack_n_d;
            disc_n_q    <= disc_n_d;
            disc_ones_q <= disc_ones_d;
            hand_q      <= hand_d;
            hand_n_q    <= hand_n_d;
            peek_q      <= peek_d;
            lib_q       <= lib_d;
            fas_q       <= fas_d;
            lfsr_q      <= lfsr_d;
            i_q         <= i_d;
            rnd_q       <= rnd_d;
            draw_pend_q <= draw_pend_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.hand      = hand_q;
    assign bus.hand_n    = hand_n_q;
    assign bus.peek      = peek_q;
    assign bus.stack_n   = stack_n_q;
    assign bus.disc_n    = disc_n_q;
    assign bus.lib_board = lib_q;
    assign bus.fas_board = fas_q;
    assign bus.game_over = game_over;
    assign bus.dbg_stack = stack_q;
    assign bus.dbg_state = state_q;
endmodule
